// File: rtl/div_issue_wb_if.sv
// Execute-side request, divider handshake, write-back port and status signals
// for the divide issue/write-back controller.
interface div_issue_wb_if;
    logic        ex_req_i;
    logic [2:0]  ex_op_i;
    logic [31:0] ex_rs1_i;
    logic [31:0] ex_rs2_i;
    logic [4:0]  ex_rd_i;
    logic        ex_ack_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [2:0]  div_op_o;
    logic        div_start_o;
    logic [31:0] div_result_i;
    logic        div_res_valid_i;
    logic        div_res_ready_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_ack_i;
    logic        flush_i;
    logic        busy_o;
    logic        rd_busy_o;
    logic [4:0]  rd_busy_addr_o;
    logic        err_o;

    modport slave (
        input  ex_req_i, ex_op_i, ex_rs1_i, ex_rs2_i, ex_rd_i,
        input  div_result_i, div_res_valid_i, wb_ack_i, flush_i,
        output ex_ack_o, div_dividend_o, div_divisor_o, div_op_o, div_start_o,
        output div_res_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o,
        output busy_o, rd_busy_o, rd_busy_addr_o, err_o
    );

    modport master (
        output ex_req_i, ex_op_i, ex_rs1_i, ex_rs2_i, ex_rd_i,
        output div_result_i, div_res_valid_i, wb_ack_i, flush_i,
        input  ex_ack_o, div_dividend_o, div_divisor_o, div_op_o, div_start_o,
        input  div_res_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o,
        input  busy_o, rd_busy_o, rd_busy_addr_o, err_o
    );
endinterface

// File: rtl/div_issue_wb.sv
// Issues one divide to the div unit, captures its result and returns it to the
// register file; flush aborts a running divide, a watchdog bounds RUN time.
module div_issue_wb #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    div_issue_wb_if.slave bus
);
    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      dividend, dividend_nx;
    logic [31:0]      divisor, divisor_nx;
    logic [2:0]       op, op_nx;
    logic [4:0]       rd, rd_nx;
    logic [31:0]      wdata, wdata_nx;
    logic             err, err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            op       <= '0;
            rd       <= '0;
            wdata    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            dividend <= dividend_nx;
            divisor  <= divisor_nx;
            op       <= op_nx;
            rd       <= rd_nx;
            wdata    <= wdata_nx;
            err      <= err_nx;
        end
    end

    // Flush beats a result arriving in the same cycle; the watchdog only fires
    // when no result is present.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        dividend_nx = dividend;
        divisor_nx  = divisor;
        op_nx       = op;
        rd_nx       = rd;
        wdata_nx    = wdata;
        err_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ex_req_i && !bus.flush_i) begin
                    dividend_nx = bus.ex_rs1_i;
                    divisor_nx  = bus.ex_rs2_i;
                    op_nx       = bus.ex_op_i;
                    rd_nx       = bus.ex_rd_i;
                    cnt_nx      = '0;
                    wdata_nx    = '0;
                    state_nx    = bus.ex_op_i[2] ? RUN : WB;
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    state_nx = IDLE;
                end else if (bus.div_res_valid_i) begin
                    wdata_nx = bus.div_result_i;
                    state_nx = WB;
                end else if (cnt == CNT_LAST) begin
                    wdata_nx = '0;
                    err_nx   = 1'b1;
                    state_nx = WB;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WB: begin
                if (bus.wb_ack_i || rd == 5'd0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ex_ack_o        = (state == IDLE) & bus.ex_req_i & ~bus.flush_i;
    assign bus.div_res_ready_o = (state == RUN) & bus.div_res_valid_i & ~bus.flush_i;

    // Remaining outputs decode directly from registers, so reset clears them at once.
    assign bus.div_dividend_o = dividend;
    assign bus.div_divisor_o  = divisor;
    assign bus.div_op_o       = op;
    assign bus.div_start_o    = (state == RUN);
    assign bus.wb_we_o        = (state == WB) & (rd != 5'd0);
    assign bus.wb_waddr_o     = rd;
    assign bus.wb_wdata_o     = wdata;
    assign bus.busy_o         = (state != IDLE);
    assign bus.rd_busy_o      = (state != IDLE) & (rd != 5'd0);
    assign bus.rd_busy_addr_o = rd;
    assign bus.err_o          = err;
endmodule
